// File: rtl/apb_ucpd_tx_enc.sv
// USB-PD TX symbol encoder: preamble, SOP ordered set, 4b5b payload, CRC-32 and EOP serialisation.
// Define UCPD_TX_BIST_EN to build in the BIST carrier (mode 2) generator.
module apb_ucpd_tx_enc #(
  parameter int unsigned PRE_LEN  = 64,
  parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF
) (
  input  logic        ic_clk,
  input  logic        ic_rst_n,
  input  logic        ucpden,
  input  logic        bit_clk_red,
  input  logic        pre_en,
  input  logic        sop_en,
  input  logic        data_en,
  input  logic        crc_en,
  input  logic        eop_en,
  input  logic        wait_en,
  input  logic        bist_en,
  input  logic        txfifo_ld_en,
  input  logic [7:0]  tx_byte,
  input  logic [19:0] tx_ordset,
  output logic        tx_bit,
  output logic [31:0] tx_crc,
  output logic        tx_bit_vld
);

  typedef enum logic [2:0] {
    PH_IDLE, PH_PRE, PH_SOP, PH_DATA, PH_CRC, PH_EOP, PH_BIST
  } phase_e;

  localparam logic [4:0]  EOP_SYM  = 5'b01101;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;

  function automatic logic [4:0] enc_4b5b(input logic [3:0] nib);
    logic [4:0] code;
    case (nib)
      4'h0: code = 5'b11110;
      4'h1: code = 5'b01001;
      4'h2: code = 5'b10100;
      4'h3: code = 5'b10101;
      4'h4: code = 5'b01010;
      4'h5: code = 5'b01011;
      4'h6: code = 5'b01110;
      4'h7: code = 5'b01111;
      4'h8: code = 5'b10010;
      4'h9: code = 5'b10011;
      4'hA: code = 5'b10110;
      4'hB: code = 5'b10111;
      4'hC: code = 5'b11010;
      4'hD: code = 5'b11011;
      4'hE: code = 5'b11100;
      default: code = 5'b11101;
    endcase
    return code;
  endfunction

  // Reflected CRC-32, one byte per call, data LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ CRC_POLY;
      else                c = c >> 1;
    end
    return c;
  endfunction

  function automatic logic [39:0] enc_crc(input logic [31:0] crc);
    logic [39:0] sym;
    sym = '0;
    for (int i = 0; i < 8; i++) sym[i*5 +: 5] = enc_4b5b(crc[i*4 +: 4]);
    return sym;
  endfunction

  logic [6:0]  phase_vec, phase_q;
  logic        phase_chg;
  phase_e      ph;
  // pos[5:0] is the symbol index; pos[6] only records an exhausted preamble.
  logic [6:0]  pos, pos_eff, pos_nxt;
  logic [7:0]  byte_hold;
  logic [9:0]  enc10;
  logic [39:0] enc40, crc_sym;
  logic [31:0] crc_reg;
  logic        sym_bit, ld_ok, pre_start, crc_start;

  assign phase_vec = {bist_en, wait_en, eop_en, crc_en, data_en, sop_en, pre_en};
  assign phase_chg = (phase_vec != phase_q);
  assign pos_eff   = phase_chg ? 7'd0 : pos;
  assign ld_ok     = txfifo_ld_en & (data_en | sop_en);
  assign pre_start = pre_en & ~phase_q[0];
  assign crc_start = crc_en & ~phase_q[3];
  assign enc10     = {enc_4b5b(byte_hold[7:4]), enc_4b5b(byte_hold[3:0])};
  assign crc_sym   = crc_start ? enc_crc(tx_crc) : enc40;
  assign tx_crc    = ~crc_reg;

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    ph = PH_IDLE;
    if      (pre_en)  ph = PH_PRE;
    else if (sop_en)  ph = PH_SOP;
    else if (data_en) ph = PH_DATA;
    else if (crc_en)  ph = PH_CRC;
    else if (eop_en)  ph = PH_EOP;
`ifdef UCPD_TX_BIST_EN
    else if (bist_en) ph = PH_BIST;
`endif
  end

  always_comb begin
    pos_nxt = (pos_eff == 7'h7F) ? pos_eff : pos_eff + 7'd1;
    case (ph)
      PH_DATA: pos_nxt = (pos_eff >= 7'd9) ? 7'd0 : pos_eff + 7'd1;
`ifdef UCPD_TX_BIST_EN
      PH_BIST: pos_nxt = {1'b0, pos_eff[5:0] + 6'd1};
`endif
      default: ;
    endcase
  end

  always_comb begin
    sym_bit = 1'b0;
    case (ph)
      PH_PRE:  sym_bit = (32'(pos_eff) < PRE_LEN) ? pos_eff[0] : 1'b0;
      PH_SOP:  if (pos_eff < 7'd20) sym_bit = tx_ordset[pos_eff[4:0]];
      PH_DATA: if (pos_eff < 7'd10) sym_bit = enc10[pos_eff[3:0]];
      PH_CRC:  if (pos_eff < 7'd40) sym_bit = crc_sym[pos_eff[5:0]];
      PH_EOP:  if (pos_eff < 7'd5)  sym_bit = EOP_SYM[pos_eff[2:0]];
`ifdef UCPD_TX_BIST_EN
      PH_BIST: sym_bit = ~pos_eff[0];
`endif
      default: sym_bit = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ic_clk or negedge ic_rst_n) begin
    if (!ic_rst_n) begin
      phase_q    <= '0;
      pos        <= '0;
      tx_bit     <= 1'b0;
      tx_bit_vld <= 1'b0;
      byte_hold  <= '0;
      crc_reg    <= CRC_INIT;
      enc40      <= '0;
    end else if (!ucpden) begin
      phase_q    <= '0;
      pos        <= '0;
      tx_bit     <= 1'b0;
      tx_bit_vld <= 1'b0;
      byte_hold  <= '0;
      crc_reg    <= CRC_INIT;
      enc40      <= '0;
    end else begin
      phase_q    <= phase_vec;
      tx_bit_vld <= (ph != PH_IDLE);

      if (bit_clk_red)    pos <= pos_nxt;
      else if (phase_chg) pos <= '0;

      if (ph == PH_IDLE)    tx_bit <= 1'b0;
      else if (bit_clk_red) tx_bit <= sym_bit;

      // A load in the same cycle as a phase change still lands; the new byte is sent next.
      if (ld_ok) begin
        byte_hold <= tx_byte;
        crc_reg   <= crc_byte(crc_reg, tx_byte);
      end else if (pre_start) begin
        crc_reg   <= CRC_INIT;
      end

      if (crc_start) enc40 <= enc_crc(tx_crc);
    end
  end

endmodule

// File: tb/tb_apb_ucpd_tx_enc.sv
// Self-checking bench for apb_ucpd_tx_enc: frame-level reference model plus hand-computed pins.
// Honours UCPD_TX_BIST_EN the same way the design does.
module tb_apb_ucpd_tx_enc;

  localparam int unsigned PRE_LEN = 64;

  typedef enum logic [2:0] {B_IDLE, B_PRE, B_SOP, B_DATA, B_CRC, B_EOP, B_WAIT, B_BIST} bph_e;

  localparam logic [4:0] LUT [16] = '{
    5'b11110, 5'b01001, 5'b10100, 5'b10101, 5'b01010, 5'b01011, 5'b01110, 5'b01111,
    5'b10010, 5'b10011, 5'b10110, 5'b10111, 5'b11010, 5'b11011, 5'b11100, 5'b11101
  };

  logic        ic_clk = 1'b0;
  logic        ic_rst_n, ucpden, bit_clk_red;
  logic        pre_en, sop_en, data_en, crc_en, eop_en, wait_en, bist_en;
  logic        txfifo_ld_en;
  logic [7:0]  tx_byte;
  logic [19:0] tx_ordset;
  logic        tx_bit, tx_bit_vld;
  logic [31:0] tx_crc;

  apb_ucpd_tx_enc #(.PRE_LEN(PRE_LEN), .CRC_INIT(32'hFFFF_FFFF)) dut (
    .ic_clk(ic_clk), .ic_rst_n(ic_rst_n), .ucpden(ucpden), .bit_clk_red(bit_clk_red),
    .pre_en(pre_en), .sop_en(sop_en), .data_en(data_en), .crc_en(crc_en),
    .eop_en(eop_en), .wait_en(wait_en), .bist_en(bist_en),
    .txfifo_ld_en(txfifo_ld_en), .tx_byte(tx_byte), .tx_ordset(tx_ordset),
    .tx_bit(tx_bit), .tx_crc(tx_crc), .tx_bit_vld(tx_bit_vld)
  );

  always #5 ic_clk = ~ic_clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  bph_e        cur_ph = B_IDLE;
  bph_e        m_prev = B_IDLE;
  int          m_k    = 0;
  logic [7:0]  m_byte = 8'h00;
  logic [39:0] m_crc40 = '0;
  logic [7:0]  m_bytes[$];
  logic        exp_bit = 1'b0;
  logic        exp_vld = 1'b0;
  logic [31:0] exp_crc = 32'h0;
  logic        last_bit;
  bit          chk_on = 1'b0;

  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (m_bytes[i]) begin
      c = c ^ {24'h0, m_bytes[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic model_sym();
    logic [9:0] c10;
    logic [4:0] eop5;
    eop5 = 5'b01101;
    c10  = {LUT[m_byte[7:4]], LUT[m_byte[3:0]]};
    case (cur_ph)
      B_PRE:  return (m_k < PRE_LEN) ? (m_k % 2 == 1) : 1'b0;
      B_SOP:  return (m_k < 20) ? tx_ordset[m_k] : 1'b0;
      B_DATA: return c10[m_k % 10];
      B_CRC:  return (m_k < 40) ? m_crc40[m_k] : 1'b0;
      B_EOP:  return (m_k < 5) ? eop5[m_k] : 1'b0;
      B_BIST: return (m_k % 2 == 0);
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_step();
    logic active;
    if (!ucpden) begin
      exp_bit = 1'b0;
      exp_vld = 1'b0;
      m_bytes.delete();
      exp_crc = ref_crc();
      m_prev  = B_IDLE;
      m_k     = 0;
      return;
    end
    active = (cur_ph inside {B_PRE, B_SOP, B_DATA, B_CRC, B_EOP});
`ifdef UCPD_TX_BIST_EN
    if (cur_ph == B_BIST) active = 1'b1;
`endif
    if (cur_ph != m_prev) begin
      m_k = 0;
      if (cur_ph == B_PRE) m_bytes.delete();
      if (cur_ph == B_CRC)
        for (int i = 0; i < 8; i++) m_crc40[i*5 +: 5] = LUT[exp_crc[i*4 +: 4]];
    end
    if (!active) exp_bit = 1'b0;
    else if (bit_clk_red) begin
      exp_bit = model_sym();
      m_k++;
    end
    exp_vld = active;
    if (txfifo_ld_en && (cur_ph == B_SOP || cur_ph == B_DATA)) begin
      m_byte = tx_byte;
      m_bytes.push_back(tx_byte);
    end
    exp_crc = ref_crc();
    m_prev  = cur_ph;
  endtask

  always @(negedge ic_clk) begin
    if (chk_on) begin
      check("tx_bit",     64'(tx_bit),     64'(exp_bit));
      check("tx_bit_vld", 64'(tx_bit_vld), 64'(exp_vld));
      check("tx_crc",     64'(tx_crc),     64'(exp_crc));
    end
  end

  task automatic set_phase(input bph_e p);
    cur_ph  = p;
    pre_en  = (p == B_PRE);
    sop_en  = (p == B_SOP);
    data_en = (p == B_DATA);
    crc_en  = (p == B_CRC);
    eop_en  = (p == B_EOP);
    wait_en = (p == B_WAIT);
    bist_en = (p == B_BIST);
  endtask

  task automatic cyc(input logic tick, input logic ld, input logic [7:0] b);
    bit_clk_red  = tick;
    txfifo_ld_en = ld;
    tx_byte      = b;
    @(posedge ic_clk);
    #1;
    model_step();
    last_bit = tx_bit;
    @(negedge ic_clk);
    bit_clk_red  = 1'b0;
    txfifo_ld_en = 1'b0;
  endtask

  task automatic send_bit(input logic ld, input logic [7:0] b, output logic sent);
    cyc(1'b1, ld, b);
    sent = last_bit;
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [63:0] v;
    logic        b;
    logic [7:0]  bist_exp;

    ic_rst_n = 1'b0;
    ucpden   = 1'b0;
    bit_clk_red = 1'b0;
    txfifo_ld_en = 1'b0;
    tx_byte  = 8'h00;
    tx_ordset = 20'h0;
    set_phase(B_IDLE);
    #1 chk_on = 1'b1;
    repeat (3) @(negedge ic_clk);
    ic_rst_n = 1'b1;
    check("reset tx_bit", 64'(tx_bit), 64'd0);
    check("reset tx_bit_vld", 64'(tx_bit_vld), 64'd0);
    check("reset tx_crc", 64'(tx_crc), 64'h0);
    cyc(1'b1, 1'b0, 8'h00);
    ucpden = 1'b1;

    // Preamble
    set_phase(B_PRE);
    v = '0;
    for (int i = 0; i < 64; i++) begin send_bit(1'b0, 8'h00, b); v[i] = b; end
    check("preamble bits", v, 64'hAAAA_AAAA_AAAA_AAAA);
    check("preamble vld", 64'(tx_bit_vld), 64'd1);
    check("crc before load", 64'(tx_crc), 64'h0);

    // SOP, first byte loaded on the last tick
    tx_ordset = 20'hC71C7;
    set_phase(B_SOP);
    v = '0;
    for (int i = 0; i < 20; i++) begin send_bit(i == 19, 8'h31, b); v[i] = b; end
    check("sop bits", 64'(v[19:0]), 64'h0C71C7);

    // Payload "123456789"
    set_phase(B_DATA);
    v = '0;
    for (int j = 0; j < 9; j++)
      for (int i = 0; i < 10; i++) begin
        send_bit((i == 9) && (j < 8), 8'h32 + 8'(j), b);
        if (j == 0) v[i] = b;
      end
    check("first data symbol", 64'(v[9:0]), 64'h2A9);
    check("crc check value", 64'(tx_crc), 64'hCBF4_3926);

    set_phase(B_CRC);
    v = '0;
    for (int i = 0; i < 40; i++) begin send_bit(1'b0, 8'h00, b); v[i] = b; end
    check("crc first nibble", 64'(v[4:0]), 64'h0E);

    set_phase(B_EOP);
    v = '0;
    for (int i = 0; i < 5; i++) begin send_bit(1'b0, 8'h00, b); v[i] = b; end
    check("eop bits", 64'(v[4:0]), 64'h0D);

    set_phase(B_WAIT);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check("wait tx_bit", 64'(tx_bit), 64'd0);
    check("wait vld", 64'(tx_bit_vld), 64'd0);

    // Second frame, dropped mid-byte
    set_phase(B_PRE);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 8'h00, b);
    set_phase(B_SOP);
    for (int i = 0; i < 20; i++) send_bit(i == 19, 8'hA5, b);
    set_phase(B_DATA);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 8'h00, b);
    check("bit before drop", 64'(b), 64'd1);
    ucpden = 1'b0;
    cyc(1'b0, 1'b0, 8'h00);
    check("drop tx_bit", 64'(tx_bit), 64'd0);
    check("drop vld", 64'(tx_bit_vld), 64'd0);
    check("drop crc", 64'(tx_crc), 64'h0);

    // Re-enable: preamble restarts, a stray load in PRE is ignored
    ucpden = 1'b1;
    set_phase(B_PRE);
    v = '0;
    for (int i = 0; i < 4; i++) begin send_bit(1'b0, 8'h00, b); v[i] = b; end
    check("restart preamble", 64'(v[3:0]), 64'hA);
    cyc(1'b0, 1'b1, 8'hFF);
    check("pre load ignored", 64'(tx_crc), 64'h0);
    set_phase(B_SOP);
    for (int i = 0; i < 20; i++) send_bit(1'b0, 8'h00, b);

    // Load on the phase-change cycle
    set_phase(B_DATA);
    cyc(1'b0, 1'b1, 8'h0F);
    v = '0;
    for (int i = 0; i < 10; i++) begin send_bit(1'b0, 8'h00, b); v[i] = b; end
    check("load at phase change", 64'(v[9:0]), 64'h3DD);

    set_phase(B_WAIT);
    cyc(1'b0, 1'b1, 8'h55);
    cyc(1'b0, 1'b0, 8'h00);

    // BIST carrier
`ifdef UCPD_TX_BIST_EN
    bist_exp = 8'h55;
`else
    bist_exp = 8'h00;
`endif
    set_phase(B_BIST);
    v = '0;
    for (int i = 0; i < 8; i++) begin send_bit(1'b0, 8'h00, b); v[i] = b; end
    check("bist bits", 64'(v[7:0]), 64'(bist_exp));

    set_phase(B_IDLE);
    repeat (3) cyc(1'b0, 1'b0, 8'h00);
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
